// File: rtl/usr_serial_frame_rx.sv
// ---------------------------------------------------------------------------
// usr_serial_frame_rx
//
// Serial frame receiver for the serial output of the universal shift
// register. Bits are sampled only on clock edges where ser_en is high.
// Line format: idle 0, start 1, WIDTH data bits MSB first, optional
// parity bit, stop 0. Each good frame is delivered in parallel with a
// one-cycle data_valid pulse. A parity error is flagged alongside the
// delivered word. A bad stop bit raises frame_err and drops the word.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   ser_in     - serial data in
//   ser_en     - bit strobe; ser_in sampled only when high
//   data_out   - last correctly framed word (first received bit = MSB)
//   data_valid - one-cycle pulse, data_out updated this cycle
//   parity_err - one-cycle pulse with data_valid on parity mismatch
//   frame_err  - one-cycle pulse when the stop bit is wrong
//   busy       - high whenever a frame is in progress (FSM not IDLE)
// ---------------------------------------------------------------------------
module usr_serial_frame_rx #(
    parameter int WIDTH      = 4,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bit;

    // High when the received parity bit disagrees with the data bits.
    // With parity disabled there is nothing to disagree with.
    function automatic logic parity_mismatch(input logic [WIDTH-1:0] d,
                                             input logic             p);
        if (PARITY_EN)
            parity_mismatch = (^d) ^ PARITY_ODD ^ p;
        else
            parity_mismatch = 1'b0;
    endfunction

    // State register: advances only on strobed edges.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else if (ser_en)
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ser_in)
                    state_nxt = DATA;
            end
            DATA: begin
                if (cnt == CNT_W'(WIDTH - 1))
                    state_nxt = PARITY_EN ? PARITY : STOP;
            end
            PARITY: state_nxt = STOP;
            // Good or bad stop bit, the line returns to IDLE; a 1 here
            // is a framing error, never a new start bit.
            STOP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered pulses. Pulses clear every cycle regardless
    // of ser_en so each lasts exactly one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (ser_en) begin
                case (state)
                    IDLE: begin
                        if (ser_in)
                            cnt <= '0;
                    end
                    DATA: begin
                        shreg <= {shreg[WIDTH-2:0], ser_in};
                        cnt   <= cnt + 1'b1;
                    end
                    PARITY: par_bit <= ser_in;
                    STOP: begin
                        if (!ser_in) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            parity_err <= parity_mismatch(shreg, par_bit);
                        end else begin
                            frame_err  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output logic.
    always_comb begin
        busy = (state != IDLE);
    end

endmodule

// File: tb/tb_usr_serial_frame_rx.sv
module tb_usr_serial_frame_rx;

    logic       clk;
    logic       reset;
    logic       ser_in;
    logic       ser_en;
    logic [3:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    usr_serial_frame_rx #(
        .WIDTH      (4),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One strobed bit; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        ser_in = b;
        ser_en = 1'b1;
        @(posedge clk);
        #1;
        ser_en = 1'b0;
    endtask

    // Send the top n bits of f, MSB first, on consecutive edges.
    task automatic send_bits(input logic [15:0] f, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit(f[i]);
    endtask

    task automatic idle_cycle();
        ser_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        ser_in = 1'b0;
        ser_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (data_out !== 4'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_good_frame();
        send_bits(16'b110111, 6);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL good_busy_mid got=%b exp=1", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL good_early_valid got=%b exp=0", data_valid); end
        send_bit(1'b0);
        total++; if (data_out !== 4'hB) begin bad++; $display("FAIL good_data got=%h exp=b", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b exp=1", data_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL good_perr got=%b exp=0", parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL good_ferr got=%b exp=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL good_busy_after got=%b exp=0", busy); end
        idle_cycle();
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL good_valid_clear got=%b exp=0", data_valid); end
        total++; if (data_out !== 4'hB) begin bad++; $display("FAIL good_data_hold got=%h exp=b", data_out); end
    endtask

    task automatic test_parity_err();
        send_bits(16'b1101100, 7);
        total++; if (data_out !== 4'hB) begin bad++; $display("FAIL perr_data got=%h exp=b", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL perr_valid got=%b exp=1", data_valid); end
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL perr_flag got=%b exp=1", parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL perr_ferr got=%b exp=0", frame_err); end
        idle_cycle();
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL perr_clear got=%b exp=0", parity_err); end
    endtask

    task automatic test_frame_err();
        send_bits(16'b1010101, 7);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", frame_err); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ferr_valid got=%b exp=0", data_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL ferr_perr got=%b exp=0", parity_err); end
        total++; if (data_out !== 4'hB) begin bad++; $display("FAIL ferr_data got=%h exp=b", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_idle got=%b exp=0", busy); end
        send_bit(1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_false_start got=%b exp=0", busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
    endtask

    task automatic test_gaps();
        logic [6:0] f;
        f = 7'b1101110;
        for (int i = 6; i >= 1; i--) begin
            send_bit(f[i]);
            for (int g = 0; g < 3; g++) begin
                ser_in = ~ser_in;
                idle_cycle();
            end
        end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL gaps_busy got=%b exp=1", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL gaps_early_valid got=%b exp=0", data_valid); end
        send_bit(f[0]);
        total++; if (data_out !== 4'hB) begin bad++; $display("FAIL gaps_data got=%h exp=b", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid got=%b exp=1", data_valid); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL gaps_perr got=%b exp=0", parity_err); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL gaps_ferr got=%b exp=0", frame_err); end
        ser_in = 1'b0;
        idle_cycle();
    endtask

    task automatic test_reset_midframe();
        send_bits(16'b110, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (data_out !== 4'h0) begin bad++; $display("FAIL rst_mid_data got=%h exp=0", data_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", data_valid); end
        send_bits(16'b1011000, 7);
        total++; if (data_out !== 4'h6) begin bad++; $display("FAIL rst_mid_frame_data got=%h exp=6", data_out); end
        total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_frame_valid got=%b exp=1", data_valid); end
        total++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL rst_mid_frame_err got=%b%b exp=00", parity_err, frame_err); end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        logic [13:0] f;
        logic        exp_v;
        f = 14'b1101110_1011000;
        for (int i = 13; i >= 0; i--) begin
            send_bit(f[i]);
            exp_v = (i == 7) || (i == 0);
            total++; if (data_valid !== exp_v) begin bad++; $display("FAIL b2b_valid bit=%0d got=%b exp=%b", 13 - i, data_valid, exp_v); end
            if (i == 7) begin
                total++; if (data_out !== 4'hB) begin bad++; $display("FAIL b2b_data1 got=%h exp=b", data_out); end
            end
            if (i == 0) begin
                total++; if (data_out !== 4'h6) begin bad++; $display("FAIL b2b_data2 got=%h exp=6", data_out); end
                total++; if (parity_err !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b%b exp=00", parity_err, frame_err); end
            end
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usr_serial_frame_rx.md
Name: usr_serial_frame_rx

Overview:
Serial frame receiver that sits directly downstream of the universal shift register's serial output (SISO/PISO path). It samples the serial bit stream on a bit-enable strobe and detects start, data, optional parity and stop fields. It delivers each completed WIDTH-bit word in parallel with a one-cycle valid pulse and error flags to downstream logic.

Parameters:
WIDTH, 4, data bits per frame (>=2); matches the shift register word.
PARITY_EN, 1, 1 = parity bit present after data; 0 = no parity field.
PARITY_ODD, 0, 0 = even parity (data bits + parity bit hold an even number of ones); 1 = odd.

Ports:
clk  input  1  single system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
ser_in  input  1  serial data from shift register serial output.
ser_en  input  1  bit strobe; ser_in sampled only on edges where ser_en=1.
data_out  output  WIDTH  last correctly framed word, MSB first as received.
data_valid  output  1  one-cycle pulse: data_out updated this cycle.
parity_err  output  1  one-cycle pulse, coincident with data_valid, on parity mismatch.
frame_err  output  1  one-cycle pulse when the stop bit is wrong.
busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Line format: idle level 0 (shift register resets to 0), start bit 1, WIDTH data bits MSB first, parity bit (if PARITY_EN), stop bit 0.
- All state changes only on edges with ser_en=1, except pulse clearing and reset. ser_en=0 holds FSM, counter and shift register unchanged.
- Reset (any cycle, including mid-frame): state IDLE, bit counter 0, shift register 0, data_out 0, data_valid 0, parity_err 0, frame_err 0, busy 0. Partial frame discarded.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: ser_in=1 -> DATA, counter=0; ser_in=0 -> stay.
  - DATA: shift ser_in into LSB (shreg <= {shreg[WIDTH-2:0], ser_in}), counter+1; after the WIDTH-th bit -> PARITY if PARITY_EN else STOP.
  - PARITY: capture parity bit; -> STOP.
  - STOP: ser_in=0 -> data_out <= shreg, data_valid=1, parity_err=computed mismatch (0 when PARITY_EN=0); ser_in=1 -> frame_err=1, data_valid=0, data_out unchanged, parity result discarded. Both -> IDLE; the bad stop bit is NOT treated as a new start bit.
- Pulses (data_valid, parity_err, frame_err) are registered, high exactly one clk cycle following the sampling edge, independent of ser_en on the next cycle.
- Parity error does not suppress delivery: data_out still updates, data_valid=1, parity_err=1.
- Latency: data_out/data_valid valid in the cycle after the ser_en edge that samples the stop bit.
- Back-to-back frames: start bit may be sampled on the very next ser_en edge after STOP; no idle bit required.
- Counter width $clog2(WIDTH)+1, never wraps mid-frame; parity = XOR of data bits XOR PARITY_ODD compared with received parity bit.
- busy=1 in DATA, PARITY, STOP; 0 in IDLE.

Test Plan:
1. WIDTH=4, even parity, ser_en=1 every cycle: bits 1,1,0,1,1,1,0 (start, 1011, parity 1, stop) -> data_out=4'hB, data_valid one cycle, parity_err=0, frame_err=0, busy low after.
2. Same frame with parity bit 0 -> data_out=4'hB, data_valid=1 and parity_err=1 same cycle.
3. After case 1, frame 1,0,1,0,1,0,1 (data 0101, parity 0, stop 1) -> frame_err pulse, data_valid=0, data_out stays 4'hB, FSM IDLE next (no false start).
4. Case 1 frame with ser_en=0 for 3 cycles between every bit and ser_in toggling during gaps -> identical result to case 1, gaps ignored.
5. Assert reset after start + 2 data bits -> all outputs 0, busy=0 next cycle; then frame 1,0,1,1,0,0,0 (data 0110, parity 0) -> data_out=4'h6, no errors.
6. Two frames back-to-back (4'hB then 4'h6, no idle bit) -> two data_valid pulses 7 ser_en edges apart, data_out 4'hB then 4'h6.
